// File: rtl/processor_pkg.sv
// Shared opcodes, control types, helper functions and boot program for the single-cycle RV32I core.
package processor_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

  typedef struct packed {
    logic     reg_write;
    logic     alu_src;
    logic     mem_write;
    logic     branch;
    logic     jump;
    wb_sel_e  wb_sel;
    imm_sel_e imm_sel;
    alu_op_e  alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write: 1'b0,
    alu_src:   1'b0,
    mem_write: 1'b0,
    branch:    1'b0,
    jump:      1'b0,
    wb_sel:    WB_ALU,
    imm_sel:   IMM_I,
    alu_op:    ALU_ADD
  };

  // Boot program, word 0 in the least significant bits; ends in a beq self-loop.
  localparam int unsigned BOOT_WORDS = 6;
  localparam logic [BOOT_WORDS*32-1:0] BOOT_PROGRAM = {
    32'h00000063,
    32'h00002203,
    32'h00302023,
    32'h002101B3,
    32'h00108113,
    32'h00100093
  };

  // Sign-extended immediate; opcode bits never contribute, so only [31:7] is taken.
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:7] ins, input imm_sel_e sel);
    logic [XLEN-1:0] imm;
    case (sel)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = XLEN'($signed(a) < $signed(b));
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/processor_register_file.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port, x0 hard-wired to zero.
module processor_register_file
  import processor_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [XLEN-1:0]   wd_i,
  output logic [XLEN-1:0]   rd1_o,
  output logic [XLEN-1:0]   rd2_o
);

  logic [XLEN-1:0] registerFile [NUM_REGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        registerFile[i] <= '0;
      end
    end else if (we_i && (wa_i != '0)) begin
      registerFile[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : registerFile[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : registerFile[ra2_i];

endmodule

// File: rtl/processor.sv
// Single-cycle RV32I-subset core: ROM fetch, decode, ALU, register file and data RAM all settle within one clock.
module processor
  import processor_pkg::*;
#(
  parameter int unsigned              IMEM_WORDS = 64,
  parameter int unsigned              DMEM_WORDS = 64,
  parameter logic [IMEM_WORDS*32-1:0] PROGRAM    = (IMEM_WORDS*32)'(BOOT_PROGRAM)
) (
  input  logic        clk,
  input  logic        reset,
  output logic        Zero,
  output logic [31:0] PC,
  output logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] ALUResult
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pc_d;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   pc_target;
  logic [31:0]       imem [IMEM_WORDS];
  logic [31:0]       instr;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_b5;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;
  ctrl_t             ctrl;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   wb_data;
  logic [XLEN-1:0]   rd_data;
  logic [DAW-1:0]    dmem_idx;

  // Data RAM powers up zeroed and is deliberately left untouched by reset.
  logic [XLEN-1:0]   data_mem [DMEM_WORDS] = '{default: '0};

  for (genvar w = 0; w < IMEM_WORDS; w++) begin : g_rom
    assign imem[w] = PROGRAM[w*32 +: 32];
  end

  assign instr     = imem[pc_q[IAW+1:2]];
  assign opcode    = instr[6:0];
  assign rd_addr   = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1_addr  = instr[19:15];
  assign rs2_addr  = instr[24:20];
  assign funct7_b5 = instr[30];

  // Main decoder; anything unrecognised falls through as a NOP.
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        case (funct3)
          F3_ADD:  ctrl.alu_op = funct7_b5 ? ALU_SUB : ALU_ADD;
          F3_AND:  ctrl.alu_op = ALU_AND;
          F3_OR:   ctrl.alu_op = ALU_OR;
          F3_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_sel   = IMM_I;
        case (funct3)
          F3_ADD:  ctrl.alu_op = ALU_ADD;
          F3_AND:  ctrl.alu_op = ALU_AND;
          F3_OR:   ctrl.alu_op = ALU_OR;
          F3_SLT:  ctrl.alu_op = ALU_SLT;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_LW: begin
        if (funct3 == F3_LSW) begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.imm_sel   = IMM_I;
          ctrl.wb_sel    = WB_MEM;
        end
      end
      OP_SW: begin
        if (funct3 == F3_LSW) begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          ctrl.imm_sel   = IMM_S;
        end
      end
      OP_BEQ: begin
        if (funct3 == F3_BEQ) begin
          ctrl.branch  = 1'b1;
          ctrl.alu_op  = ALU_SUB;
          ctrl.imm_sel = IMM_B;
        end
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        ctrl.imm_sel   = IMM_J;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  assign imm     = imm_gen(instr[31:7], ctrl.imm_sel);
  assign alu_b   = ctrl.alu_src ? imm : rs2_data;
  assign alu_res = alu_eval(ctrl.alu_op, rs1_data, alu_b);

  processor_register_file register (
    .clk_i (clk),
    .rst_i (reset),
    .we_i  (ctrl.reg_write),
    .ra1_i (rs1_addr),
    .ra2_i (rs2_addr),
    .wa_i  (rd_addr),
    .wd_i  (wb_data),
    .rd1_o (rs1_data),
    .rd2_o (rs2_data)
  );

  // Word-addressed RAM; byte offset bits are ignored and the index wraps.
  assign dmem_idx = alu_res[DAW+1:2];
  assign rd_data  = data_mem[dmem_idx];

  always_ff @(posedge clk) begin
    if (ctrl.mem_write) begin
      data_mem[dmem_idx] <= rs2_data;
    end
  end

  always_comb begin
    case (ctrl.wb_sel)
      WB_MEM:  wb_data = rd_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  // Branch decision reuses the subtract result's zero flag.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    pc_target = pc_q + imm;
    pc_d      = pc_plus4;
    if (ctrl.jump || (ctrl.branch && Zero)) begin
      pc_d = pc_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign Zero      = (alu_res == '0);
  assign PC        = pc_q;
  assign WriteData = rs2_data;
  assign ReadData  = rd_data;
  assign ALUResult = alu_res;

endmodule

// File: tb/tb_processor.sv
// Bench for the single-cycle core: five instances run different ROM images against an instruction-level model.
module tb_processor;

  localparam int unsigned NDUT = 5;

  localparam logic [2047:0] P_DEF = 2048'({32'h00000063, 32'h00002203, 32'h00302023,
                                           32'h002101B3, 32'h00108113, 32'h00100093});
  localparam logic [2047:0] P_X0  = 2048'({32'h00000063, 32'h000002B3, 32'h00500013});
  localparam logic [2047:0] P_AR  = 2048'({32'h00000063, 32'h400001B3, 32'h0000A133, 32'hFFF00093});
  localparam logic [2047:0] P_CF  = 2048'({32'h00000063, 32'hFFF00393, 32'h008000EF, 32'h00000000,
                                           32'h00208463, 32'h00200113, 32'h00100093});

  // Pseudo-random straight-line program of ALU, load and store instructions.
  function automatic logic [2047:0] gen_rand_prog(input int unsigned seed);
    logic [2047:0] p;
    logic [31:0]   w;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [11:0]   imm;
    int unsigned   s;
    int unsigned   kind;
    p = '0;
    s = seed;
    for (int i = 0; i < 48; i++) begin
      s = s * 1664525 + 1013904223; rd   = 5'(1 + (s >> 24) % 7);
      s = s * 1664525 + 1013904223; rs1  = 5'((s >> 24) % 8);
      s = s * 1664525 + 1013904223; rs2  = 5'((s >> 24) % 8);
      s = s * 1664525 + 1013904223; imm  = 12'(s >> 20);
      s = s * 1664525 + 1013904223; kind = (i == 0) ? 0 : (s >> 24) % 11;
      case (kind)
        0:       w = {imm, rs1, 3'b000, rd, 7'h13};
        1:       w = {imm, rs1, 3'b111, rd, 7'h13};
        2:       w = {imm, rs1, 3'b110, rd, 7'h13};
        3:       w = {imm, rs1, 3'b010, rd, 7'h13};
        4:       w = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
        5:       w = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
        6:       w = {7'h00, rs2, rs1, 3'b111, rd, 7'h33};
        7:       w = {7'h00, rs2, rs1, 3'b110, rd, 7'h33};
        8:       w = {7'h00, rs2, rs1, 3'b010, rd, 7'h33};
        9:       w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
        default: w = {imm, rs1, 3'b010, rd, 7'h03};
      endcase
      p[i*32 +: 32] = w;
    end
    return p;
  endfunction

  localparam logic [2047:0] P_RND = gen_rand_prog(32'h1234_5678);

  logic             clk = 1'b0;
  logic [NDUT-1:0]  rst_v;
  logic [NDUT-1:0]  zero_v;
  logic [31:0]      pc_v  [NDUT];
  logic [31:0]      wd_v  [NDUT];
  logic [31:0]      rd_v  [NDUT];
  logic [31:0]      alu_v [NDUT];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_imem [64];
  logic [31:0] m_mem  [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  processor dut_def (
    .clk(clk), .reset(rst_v[0]), .Zero(zero_v[0]), .PC(pc_v[0]),
    .WriteData(wd_v[0]), .ReadData(rd_v[0]), .ALUResult(alu_v[0])
  );
  processor #(.PROGRAM(P_X0)) dut_x0 (
    .clk(clk), .reset(rst_v[1]), .Zero(zero_v[1]), .PC(pc_v[1]),
    .WriteData(wd_v[1]), .ReadData(rd_v[1]), .ALUResult(alu_v[1])
  );
  processor #(.PROGRAM(P_AR)) dut_ar (
    .clk(clk), .reset(rst_v[2]), .Zero(zero_v[2]), .PC(pc_v[2]),
    .WriteData(wd_v[2]), .ReadData(rd_v[2]), .ALUResult(alu_v[2])
  );
  processor #(.PROGRAM(P_CF)) dut_cf (
    .clk(clk), .reset(rst_v[3]), .Zero(zero_v[3]), .PC(pc_v[3]),
    .WriteData(wd_v[3]), .ReadData(rd_v[3]), .ALUResult(alu_v[3])
  );
  processor #(.PROGRAM(P_RND)) dut_rnd (
    .clk(clk), .reset(rst_v[4]), .Zero(zero_v[4]), .PC(pc_v[4]),
    .WriteData(wd_v[4]), .ReadData(rd_v[4]), .ALUResult(alu_v[4])
  );

  function automatic logic [31:0] dut_reg(input int d, input int r);
    case (d)
      0:       return dut_def.register.registerFile[5'(r)];
      1:       return dut_x0.register.registerFile[5'(r)];
      2:       return dut_ar.register.registerFile[5'(r)];
      3:       return dut_cf.register.registerFile[5'(r)];
      default: return dut_rnd.register.registerFile[5'(r)];
    endcase
  endfunction

  task automatic load_model(input logic [2047:0] p);
    for (int i = 0; i < 64; i++) begin
      m_imem[i] = p[i*32 +: 32];
      m_mem[i]  = 32'h0;
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  // Instruction-set level model: one call retires one instruction.
  task automatic iss_step();
    logic [31:0] ins, a, b, res, addr, nxt, immi, imms, immb, immj;
    int          sgn;
    logic        wr;
    ins  = m_imem[m_pc[7:2]];
    a    = m_regs[ins[19:15]];
    b    = m_regs[ins[24:20]];
    sgn  = ins[31] ? -1 : 0;
    immi = 32'(sgn * 2048 + int'(ins[30:20]));
    imms = 32'(sgn * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]));
    immb = 32'(sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
    immj = 32'(sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
    nxt  = m_pc + 4;
    wr   = 1'b0;
    res  = 32'h0;
    case (ins[6:0])
      7'h33: begin
        wr = 1'b1;
        case (ins[14:12])
          3'd0:    res = ins[30] ? a - b : a + b;
          3'd7:    res = a & b;
          3'd6:    res = a | b;
          3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
      end
      7'h13: begin
        wr = 1'b1;
        case (ins[14:12])
          3'd0:    res = a + immi;
          3'd7:    res = a & immi;
          3'd6:    res = a | immi;
          3'd2:    res = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
          default: wr = 1'b0;
        endcase
      end
      7'h03: begin addr = a + immi; res = m_mem[addr[7:2]]; wr = 1'b1; end
      7'h23: begin addr = a + imms; m_mem[addr[7:2]] = b; end
      7'h63: if (a == b) nxt = m_pc + immb;
      7'h6F: begin res = m_pc + 4; wr = 1'b1; nxt = m_pc + immj; end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    m_pc = nxt;
  endtask

  // Pulse reset on one instance for two cycles, releasing it on a falling edge.
  task automatic do_reset(input int d);
    @(negedge clk);
    rst_v[d] = 1'b1;
    repeat (2) @(negedge clk);
    rst_v[d] = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pc_v[0] !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", pc_v[0], 32'h0); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (dut_reg(0, r) !== 32'h0) begin
        errors++; $display("FAIL reset_reg x%0d got %h want %h", r, dut_reg(0, r), 32'h0);
      end
    end
    checks++;
    if (alu_v[0] !== 32'h1) begin errors++; $display("FAIL reset_alu got %h want %h", alu_v[0], 32'h1); end
    checks++;
    if (zero_v[0] !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want %b", zero_v[0], 1'b0); end
    rst_v[0] = 1'b0;
  endtask

  task automatic test_default_program();
    load_model(P_DEF);
    do_reset(0);
    for (int c = 0; c < 50; c++) begin
      checks++;
      if (pc_v[0] !== m_pc) begin errors++; $display("FAIL def_pc cyc %0d got %h want %h", c, pc_v[0], m_pc); end
      if (m_pc == 32'hC) begin
        checks += 3;
        if (alu_v[0] !== 32'h0) begin errors++; $display("FAIL store_alu got %h want %h", alu_v[0], 32'h0); end
        if (wd_v[0] !== 32'h4) begin errors++; $display("FAIL store_wdata got %h want %h", wd_v[0], 32'h4); end
        if (zero_v[0] !== 1'b1) begin errors++; $display("FAIL store_zero got %b want %b", zero_v[0], 1'b1); end
      end
      if (m_pc == 32'h10) begin
        checks++;
        if (rd_v[0] !== 32'h4) begin errors++; $display("FAIL load_rdata got %h want %h", rd_v[0], 32'h4); end
      end
      iss_step();
      @(negedge clk);
    end
    checks += 6;
    if (dut_reg(0, 1) !== 32'd1) begin errors++; $display("FAIL def_x1 got %h want %h", dut_reg(0, 1), 32'd1); end
    if (dut_reg(0, 2) !== 32'd2) begin errors++; $display("FAIL def_x2 got %h want %h", dut_reg(0, 2), 32'd2); end
    if (dut_reg(0, 3) !== 32'd4) begin errors++; $display("FAIL def_x3 got %h want %h", dut_reg(0, 3), 32'd4); end
    if (dut_reg(0, 4) !== 32'd4) begin errors++; $display("FAIL def_x4 got %h want %h", dut_reg(0, 4), 32'd4); end
    if (dut_def.data_mem[0] !== 32'd4) begin
      errors++; $display("FAIL def_mem0 got %h want %h", dut_def.data_mem[0], 32'd4);
    end
    if (pc_v[0] !== 32'h14) begin errors++; $display("FAIL def_halt_pc got %h want %h", pc_v[0], 32'h14); end
  endtask

  task automatic test_x0_write();
    load_model(P_X0);
    do_reset(1);
    checks++;
    if (alu_v[1] !== 32'h5) begin errors++; $display("FAIL x0_alu got %h want %h", alu_v[1], 32'h5); end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (pc_v[1] !== m_pc) begin errors++; $display("FAIL x0_pc cyc %0d got %h want %h", c, pc_v[1], m_pc); end
      iss_step();
      @(negedge clk);
    end
    checks += 2;
    if (dut_reg(1, 0) !== 32'h0) begin errors++; $display("FAIL x0_kept got %h want %h", dut_reg(1, 0), 32'h0); end
    if (dut_reg(1, 5) !== 32'h0) begin errors++; $display("FAIL x0_x5 got %h want %h", dut_reg(1, 5), 32'h0); end
  endtask

  task automatic test_arith_edges();
    load_model(P_AR);
    do_reset(2);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (pc_v[2] !== m_pc) begin errors++; $display("FAIL ar_pc cyc %0d got %h want %h", c, pc_v[2], m_pc); end
      if (m_pc == 32'h4) begin
        checks++;
        if (alu_v[2] !== 32'h1) begin errors++; $display("FAIL slt_alu got %h want %h", alu_v[2], 32'h1); end
      end
      if (m_pc == 32'h8) begin
        checks += 2;
        if (alu_v[2] !== 32'h0) begin errors++; $display("FAIL sub_alu got %h want %h", alu_v[2], 32'h0); end
        if (zero_v[2] !== 1'b1) begin errors++; $display("FAIL sub_zero got %b want %b", zero_v[2], 1'b1); end
      end
      iss_step();
      @(negedge clk);
    end
    checks += 3;
    if (dut_reg(2, 1) !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ar_x1 got %h want %h", dut_reg(2, 1), 32'hFFFF_FFFF); end
    if (dut_reg(2, 2) !== 32'h1) begin errors++; $display("FAIL ar_x2 got %h want %h", dut_reg(2, 2), 32'h1); end
    if (dut_reg(2, 3) !== 32'h0) begin errors++; $display("FAIL ar_x3 got %h want %h", dut_reg(2, 3), 32'h0); end
  endtask

  task automatic test_control_flow();
    load_model(P_CF);
    do_reset(3);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (pc_v[3] !== m_pc) begin errors++; $display("FAIL cf_pc cyc %0d got %h want %h", c, pc_v[3], m_pc); end
      if (m_pc == 32'h8) begin
        checks++;
        if (zero_v[3] !== 1'b0) begin errors++; $display("FAIL beq_nt_zero got %b want %b", zero_v[3], 1'b0); end
      end
      iss_step();
      @(negedge clk);
    end
    checks += 4;
    if (dut_reg(3, 1) !== 32'h14) begin errors++; $display("FAIL jal_link got %h want %h", dut_reg(3, 1), 32'h14); end
    if (dut_reg(3, 2) !== 32'h2) begin errors++; $display("FAIL cf_x2 got %h want %h", dut_reg(3, 2), 32'h2); end
    if (dut_reg(3, 7) !== 32'h0) begin errors++; $display("FAIL jal_skip got %h want %h", dut_reg(3, 7), 32'h0); end
    if (pc_v[3] !== 32'h18) begin errors++; $display("FAIL jal_pc got %h want %h", pc_v[3], 32'h18); end
  endtask

  task automatic test_random_reset();
    int unsigned n1, n2, dly;
    load_model(P_RND);
    do_reset(4);
    n1 = $urandom_range(10, 60);
    for (int c = 0; c < int'(n1); c++) begin
      checks++;
      if (pc_v[4] !== m_pc) begin errors++; $display("FAIL rnd_pc1 cyc %0d got %h want %h", c, pc_v[4], m_pc); end
      iss_step();
      @(negedge clk);
    end
    @(posedge clk);
    dly = $urandom_range(1, 3);
    #(dly);
    rst_v[4] = 1'b1;
    #1;
    checks++;
    if (pc_v[4] !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h want %h", pc_v[4], 32'h0); end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (dut_reg(4, r) !== 32'h0) begin
        errors++; $display("FAIL midrst_reg x%0d got %h want %h", r, dut_reg(4, r), 32'h0);
      end
    end
    model_reset();
    @(negedge clk);
    rst_v[4] = 1'b0;
    n2 = $urandom_range(40, 120);
    for (int c = 0; c < int'(n2); c++) begin
      checks++;
      if (pc_v[4] !== m_pc) begin errors++; $display("FAIL rnd_pc2 cyc %0d got %h want %h", c, pc_v[4], m_pc); end
      iss_step();
      @(negedge clk);
    end
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (dut_reg(4, r) !== m_regs[r]) begin
        errors++; $display("FAIL rnd_reg x%0d got %h want %h", r, dut_reg(4, r), m_regs[r]);
      end
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (dut_rnd.data_mem[i] !== m_mem[i]) begin
        errors++; $display("FAIL rnd_mem w%0d got %h want %h", i, dut_rnd.data_mem[i], m_mem[i]);
      end
    end
  endtask

  initial begin
    rst_v = '0;
    #2;
    rst_v = '1;
    test_reset();
    test_default_program();
    test_x0_write();
    test_arith_edges();
    test_control_flow();
    test_random_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/processor.md
Name: processor

Overview:
- Single-cycle 32-bit RISC-V (RV32I subset) processor with internal instruction ROM, register file and data RAM.
- Each instruction is fetched, executed and retired in one clock cycle.
- Observable datapath signals (PC, ALU result, Zero, store data, load data) are exported for waveform and bench checks.
- Top-level, self-contained block with no external memory bus.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 64, data RAM depth in 32-bit words.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Zero  output  1  ALU zero flag (ALUResult == 0), combinational.
- PC  output  32  current program counter (byte address).
- WriteData  output  32  rs2 read value (store data), combinational.
- ReadData  output  32  data RAM read value at ALUResult, combinational.
- ALUResult  output  32  ALU output of the current instruction, combinational.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset state:
  - PC = 0.
  - All 32 registers = 0.
  - Data RAM is not cleared; it is zero-initialised at time 0.
  - Derived outputs follow combinationally from PC=0 and zeroed registers.
- Fetch: instruction = IMEM[PC[7:2]]; PC bits [1:0] are ignored; the index wraps modulo 64.
- Next PC:
  - PC+4 by default.
  - PC + B-immediate when beq is taken (Zero=1).
  - PC + J-immediate for jal.
  - PC updates on the rising edge.
- Supported instructions:
  - R-type: add, sub, and, or, slt.
  - I-type: addi, andi, ori, slti.
  - lw, sw, beq, jal.
  - Immediates are sign-extended per RV32I formats.
- ALU: 32-bit wrap-around add/sub; slt is a signed compare producing 0 or 1.
- Addressing: lw/sw address = rs1 + I/S-immediate.
- Register file:
  - Two combinational read ports, one write port written on the rising edge when RegWrite=1.
  - Write-back source: ALUResult, ReadData (lw) or PC+4 (jal).
  - Register 0 always reads 0; writes to it are discarded.
- Data RAM:
  - Word access at ALUResult[7:2]; the index wraps modulo 64.
  - Write on the rising edge when MemWrite=1; read is combinational.
  - Misaligned low bits are ignored.
- Unknown opcode: NOP. No register or memory write, PC+4.
- Reset asserted mid-program: PC and registers clear immediately, without waiting for a clock edge. After release, execution restarts at address 0.
- Hierarchy (the bench probes these names):
  - Register-file instance named register.
  - Its storage is an array named registerFile, indices 0..31, 32 bits each.
- Built-in ROM program, from word 0:
  - 0x00100093  addi x1,x0,1
  - 0x00108113  addi x2,x1,1
  - 0x002101B3  add x3,x2,x2
  - 0x00302023  sw x3,0(x0)
  - 0x00002203  lw x4,0(x0)
  - 0x00000063  beq x0,x0,0 (self-loop, halts progress)
  - All remaining words are 0 (NOP).

Decomposition:
- Shared package:
  - Opcode constants: OP_R=0110011, OP_I=0010011, OP_LW=0000011, OP_SW=0100011, OP_BEQ=1100011, OP_JAL=1101111.
  - ALU control codes: ADD, SUB, AND, OR, SLT.
  - Immediate-select enum.
- One natural sub-module: register_file, instantiated as register.
- Control decode, ALU and memories stay in the top level.

Test Plan:
- Reset: hold reset for 20 ns (2 cycles) -> PC=0, all registerFile entries 0. Assert reset between clock edges mid-run -> PC returns to 0 immediately.
- Default program, 50 cycles after reset release:
  - x1=1, x2=2, x3=4, x4=4.
  - Data RAM word 0 = 4.
  - PC stuck at 0x14.
- Store cycle of the default program -> ALUResult=0, WriteData=4, Zero=1. Load cycle -> ReadData=4.
- Write to x0: load ROM with addi x0,x0,5 then add x5,x0,x0 -> x0 stays 0, x5=0.
- Arithmetic edges:
  - addi x1,x0,-1; slt x2,x1,x0 -> x1=0xFFFFFFFF, x2=1.
  - sub x3,x0,x0 -> x3=0 with Zero=1.
- Control flow:
  - beq not taken (x1=1, x2=2) -> PC+4.
  - jal x1,8 at PC=0x10 -> x1=0x14, PC=0x18.
